// File: rtl/serial_add_if.sv
// Handshake and operand/result bundle for serial_add.
// The cout/ovf flags exist only when SERIAL_ADD_FLAGS_EN is defined.
interface serial_add_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ans;
`ifdef SERIAL_ADD_FLAGS_EN
  logic             cout;
  logic             ovf;
`endif

  modport master (
    output start, op1, op2, cin,
`ifdef SERIAL_ADD_FLAGS_EN
    input  cout, ovf,
`endif
    input  busy, done, ans
  );

  modport slave (
    input  start, op1, op2, cin,
`ifdef SERIAL_ADD_FLAGS_EN
    output cout, ovf,
`endif
    output busy, done, ans
  );
endinterface

// File: rtl/serial_add.sv
// Bit-serial adder: one full adder plus a carry flop, LSB first, one bit per clock.
// Define SERIAL_ADD_FLAGS_EN to add registered cout/ovf flags updated with ans.
module serial_add #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  serial_add_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_s;
  logic             fa_c;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] ans_r;
`ifdef SERIAL_ADD_FLAGS_EN
  logic             cout_r;
  logic             ovf_r;
`endif

  always_comb begin
    fa_s     = a_sh[0] ^ b_sh[0] ^ carry;
    fa_c     = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    sum_next = sum_sh >> 1;
    sum_next[WIDTH-1] = fa_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      ans_r  <= '0;
`ifdef SERIAL_ADD_FLAGS_EN
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_sh   <= bus.op1;
            b_sh   <= bus.op2;
            carry  <= bus.cin;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_c;
          sum_sh <= sum_next;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            ans_r  <= sum_next;
`ifdef SERIAL_ADD_FLAGS_EN
            // On the MSB step, carry holds the carry into the MSB and fa_c the carry out.
            cout_r <= fa_c;
            ovf_r  <= carry ^ fa_c;
`endif
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.ans  = ans_r;
`ifdef SERIAL_ADD_FLAGS_EN
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;
`endif
endmodule

// File: tb/tb_serial_add.sv
// Directed self-checking bench for serial_add (WIDTH=8), flags checked when SERIAL_ADD_FLAGS_EN is set.
module tb_serial_add;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  serial_add_if #(.WIDTH(8)) bus ();
  serial_add #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Drive a start at the negedge; returns right after the accepting posedge with start dropped.
  task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic c);
    @(negedge clk);
    bus.start = 1'b1; bus.op1 = x; bus.op2 = y; bus.cin = c;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op1 = 8'h5A; bus.op2 = 8'hC3; bus.cin = 1'b1;
  endtask

  // Count negedge samples after acceptance until done is seen (bounded).
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc = 0; busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) break;
    end
  endtask

  task automatic check_op(input string nm, input logic [7:0] x, input logic [7:0] y, input logic c,
                          input logic [7:0] exp_ans, input logic exp_cout, input logic exp_ovf,
                          input bit chk_flags);
    int cyc, bc;
    issue(x, y, c);
    wait_done(cyc, bc);
    total++;
    if (cyc !== 9 || bus.done !== 1'b1) begin
      bad++; $display("FAIL %s latency: got %0d cycles done=%b, want 9 done=1", nm, cyc, bus.done);
    end
    total++;
    if (bc !== 8) begin
      bad++; $display("FAIL %s busy_len: got %0d, want 8", nm, bc);
    end
    total++;
    if (bus.ans !== exp_ans) begin
      bad++; $display("FAIL %s ans: got %h, want %h", nm, bus.ans, exp_ans);
    end
`ifdef SERIAL_ADD_FLAGS_EN
    if (chk_flags) begin
      total++;
      if (bus.cout !== exp_cout || bus.ovf !== exp_ovf) begin
        bad++; $display("FAIL %s flags: got cout=%b ovf=%b, want cout=%b ovf=%b",
                        nm, bus.cout, bus.ovf, exp_cout, exp_ovf);
      end
    end
`else
    if (chk_flags && (exp_cout === 1'bx || exp_ovf === 1'bx)) $display("note: flags unchecked");
`endif
    @(negedge clk);
    total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.ans !== exp_ans) begin
      bad++; $display("FAIL %s after_done: got done=%b busy=%b ans=%h, want 0 0 %h",
                      nm, bus.done, bus.busy, bus.ans, exp_ans);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ans !== 8'h00) begin
      bad++; $display("FAIL reset: got busy=%b done=%b ans=%h, want 0 0 00", bus.busy, bus.done, bus.ans);
    end
`ifdef SERIAL_ADD_FLAGS_EN
    total++;
    if (bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      bad++; $display("FAIL reset_flags: got cout=%b ovf=%b, want 0 0", bus.cout, bus.ovf);
    end
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    check_op("basic_35_12", 8'h35, 8'h12, 1'b0, 8'h47, 1'b0, 1'b0, 1'b1);
    check_op("cin_add", 8'h0F, 8'h10, 1'b1, 8'h20, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_inverse;
    check_op("inv_23_12", 8'h23, 8'h12, 1'b0, 8'h35, 1'b0, 1'b0, 1'b1);
    check_op("inv_35_EE", 8'h35, 8'hEE, 1'b0, 8'h23, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_wrap;
    check_op("wrap_FF_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    check_op("ovf_7F_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
    check_op("max_FF_FF_1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_ignore_start;
    int cyc, bc;
    issue(8'h10, 8'h01, 1'b0);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.op1 = 8'hAA; bus.op2 = 8'h55; bus.cin = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc, bc);
    total++;
    if (cyc !== 6 || bus.done !== 1'b1) begin
      bad++; $display("FAIL ignore_latency: got %0d more cycles done=%b, want 6 done=1", cyc, bus.done);
    end
    total++;
    if (bus.ans !== 8'h11) begin
      bad++; $display("FAIL ignore_ans: got %h, want 11", bus.ans);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int cyc, bc;
    issue(8'h35, 8'h12, 1'b0);
    wait_done(cyc, bc);
    total++;
    if (cyc !== 9 || bus.ans !== 8'h47) begin
      bad++; $display("FAIL b2b_first: got cyc=%0d ans=%h, want 9 47", cyc, bus.ans);
    end
    bus.start = 1'b1; bus.op1 = 8'h23; bus.op2 = 8'h12; bus.cin = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      bad++; $display("FAIL b2b_no_gap: got busy=%b done=%b, want 1 0", bus.busy, bus.done);
    end
    wait_done(cyc, bc);
    total++;
    if (cyc !== 8 || bus.done !== 1'b1 || bus.ans !== 8'h35) begin
      bad++; $display("FAIL b2b_second: got cyc=%0d done=%b ans=%h, want 8 1 35", cyc, bus.done, bus.ans);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int cyc, bc;
    int seen_done;
    issue(8'h35, 8'h12, 1'b0);
    for (int i = 0; i < 4; i++) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ans !== 8'h00) begin
      bad++; $display("FAIL rst_mid: got busy=%b done=%b ans=%h, want 0 0 00", bus.busy, bus.done, bus.ans);
    end
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen_done++;
    end
    total++;
    if (seen_done !== 0) begin
      bad++; $display("FAIL rst_abort: got %0d active cycles, want 0", seen_done);
    end
    check_op("post_rst_01_01", 8'h01, 8'h01, 1'b1, 8'h03, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    bus.start = 1'b0; bus.op1 = '0; bus.op2 = '0; bus.cin = 1'b0;
    test_reset;
    test_basic;
    test_inverse;
    test_wrap;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid_run;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
